// File: rtl/pattern_pkg.sv
// Shared encodings for the pattern packet sequencer: command codes, status codes,
// channel mode/idle levels, control-byte field positions and FSM state types.
package pattern_pkg;

    localparam logic [1:0] CMD_STOP       = 2'b00;
    localparam logic [1:0] CMD_LOAD_START = 2'b01;
    localparam logic [1:0] CMD_LOAD       = 2'b10;
    localparam logic [1:0] CMD_RSVD       = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_INVALID = 2'b01;
    localparam logic [1:0] ST_BUSY    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_REPEAT   = 1'b1;
    localparam logic IDLE_LOW      = 1'b0;
    localparam logic IDLE_HIGH     = 1'b1;

    localparam int CTRL_CH_MSB   = 7;
    localparam int CTRL_CH_LSB   = 4;
    localparam int CTRL_IDLE_BIT = 3;
    localparam int CTRL_MODE_BIT = 2;
    localparam int CTRL_CMD_MSB  = 1;
    localparam int CTRL_CMD_LSB  = 0;

    // Channel field reported with a timeout, since no control byte was received.
    localparam logic [3:0] CH_TIMEOUT = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_LOAD, S_START, S_REPORT} disp_state_e;
    typedef enum logic {A_IDLE, A_WAIT} ack_state_e;

endpackage

// File: rtl/pkt_byte_collector.sv
// Shifts RX bytes into a packet buffer, hands each complete packet to a hold register,
// and discards a partial packet when the inter-byte gap exceeds the timeout.
module pkt_byte_collector #(
    parameter int PACK_NUM    = 9,
    parameter int TIMEOUT_CLK = 10420,
    parameter int TO_BIT      = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            i_data,
    input  logic                  i_rx_done_tick,
    output logic [PACK_NUM*8-1:0] o_hold,
    output logic                  o_pkt_done,
    output logic                  o_timeout
);

    localparam int PKT_W = PACK_NUM * 8;
    localparam int CNT_W = $clog2(PACK_NUM + 1);

    logic [PKT_W-1:0]  pkt_q;
    logic [PKT_W-1:0]  pkt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_BIT-1:0] to_q;

    assign pkt_d      = {i_data, pkt_q[PKT_W-1:8]};
    assign o_pkt_done = i_rx_done_tick && (cnt_q == CNT_W'(PACK_NUM - 1));
    // A byte arriving in the expiry cycle wins over the timeout.
    assign o_timeout  = !i_rx_done_tick && (cnt_q != '0) && (to_q == TO_BIT'(TIMEOUT_CLK - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
            to_q  <= '0;
        end else if (i_rx_done_tick) begin
            to_q  <= '0;
            cnt_q <= o_pkt_done ? '0 : cnt_q + 1'b1;
        end else if (o_timeout) begin
            cnt_q <= '0;
            to_q  <= '0;
        end else if (cnt_q != '0) begin
            to_q <= to_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rx_done_tick) pkt_q <= pkt_d;
        if (o_pkt_done)     o_hold <= pkt_d;
    end

endmodule

// File: rtl/pattern_packet_sequencer.sv
// Decodes 9-byte UART command packets into per-channel pattern loads and start/stop strobes.
// Status echo over UART TX (ACK FSM) is compiled in only when PKT_SEQ_ACK_EN is defined.
module pattern_packet_sequencer
    import pattern_pkg::*;
#(
    parameter int DATA_BIT    = 32,
    parameter int PACK_NUM    = 9,
    parameter int CH_NUM      = 3,
    parameter int TIMEOUT_CLK = 10420,
    parameter int TO_BIT      = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_rx_done_tick,
    input  logic [CH_NUM-1:0]   i_busy,
    output logic [DATA_BIT-1:0] o_out_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic                o_mode,
    output logic                o_idle_level,
    output logic [CH_NUM-1:0]   o_load,
    output logic [CH_NUM-1:0]   o_start,
    output logic [CH_NUM-1:0]   o_stop,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_done_tick,
    output logic                o_err_tick,
    output logic                o_ack_ovf
);

    localparam int PKT_W = PACK_NUM * 8;

    logic [PKT_W-1:0] hold;
    logic             pkt_done;
    logic             timeout;

    pkt_byte_collector #(
        .PACK_NUM    (PACK_NUM),
        .TIMEOUT_CLK (TIMEOUT_CLK),
        .TO_BIT      (TO_BIT)
    ) u_collector (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_data         (i_data),
        .i_rx_done_tick (i_rx_done_tick),
        .o_hold         (hold),
        .o_pkt_done     (pkt_done),
        .o_timeout      (timeout)
    );

    function automatic logic [CH_NUM-1:0] ch_onehot(input logic [3:0] c);
        logic [CH_NUM-1:0] r;
        for (int i = 0; i < CH_NUM; i++) r[i] = (32'(c) == i);
        return r;
    endfunction

    logic [7:0]        ctrl;
    logic [3:0]        ch;
    logic [1:0]        cmd;
    logic              ch_ok;
    logic [CH_NUM-1:0] ch_oh;

    assign ctrl  = hold[PKT_W-1 -: 8];
    assign ch    = ctrl[CTRL_CH_MSB:CTRL_CH_LSB];
    assign cmd   = ctrl[CTRL_CMD_MSB:CTRL_CMD_LSB];
    assign ch_ok = 32'(ch) < CH_NUM;
    assign ch_oh = ch_onehot(ch);

    disp_state_e         state_q;
    logic [CH_NUM-1:0]   load_q, start_q, stop_q;
    logic [DATA_BIT-1:0] out_q, freq_q;
    logic                mode_q, idle_q, err_q;
    logic [7:0]          status_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            load_q   <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            out_q    <= '0;
            freq_q   <= '0;
            mode_q   <= MODE_ONE_SHOT;
            idle_q   <= IDLE_LOW;
            err_q    <= 1'b0;
            status_q <= '0;
        end else begin
            load_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pkt_done) begin
                        state_q <= S_DECODE;
                    end else if (timeout) begin
                        status_q <= {CH_TIMEOUT, 2'b00, ST_TIMEOUT};
                        err_q    <= 1'b1;
                        state_q  <= S_REPORT;
                    end
                end
                S_DECODE: begin
                    state_q <= S_REPORT;
                    if (!ch_ok || cmd == CMD_RSVD) begin
                        status_q <= {ch, 2'b00, ST_INVALID};
                        err_q    <= 1'b1;
                    end else if (cmd == CMD_STOP) begin
                        // Stop is honoured regardless of the channel's busy level.
                        stop_q   <= ch_oh;
                        status_q <= {ch, 2'b00, ST_OK};
                    end else if (|(i_busy & ch_oh)) begin
                        status_q <= {ch, 2'b00, ST_BUSY};
                        err_q    <= 1'b1;
                    end else begin
                        load_q   <= ch_oh;
                        out_q    <= hold[DATA_BIT-1:0];
                        freq_q   <= hold[2*DATA_BIT-1:DATA_BIT];
                        mode_q   <= ctrl[CTRL_MODE_BIT] ? MODE_REPEAT : MODE_ONE_SHOT;
                        idle_q   <= ctrl[CTRL_IDLE_BIT] ? IDLE_HIGH : IDLE_LOW;
                        status_q <= {ch, 2'b00, ST_OK};
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    case (cmd)
                        CMD_LOAD_START: begin
                            start_q <= ch_oh;
                            state_q <= S_START;
                        end
                        CMD_LOAD: state_q <= S_REPORT;
                        default:  state_q <= S_REPORT;
                    endcase
                end
                S_START:  state_q <= S_REPORT;
                S_REPORT: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign o_out_pattern  = out_q;
    assign o_freq_pattern = freq_q;
    assign o_mode         = mode_q;
    assign o_idle_level   = idle_q;
    assign o_load         = load_q;
    assign o_start        = start_q;
    assign o_stop         = stop_q;
    assign o_err_tick     = err_q;

`ifdef PKT_SEQ_ACK_EN
    ack_state_e ack_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic       ovf_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ack_q      <= A_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (ack_q)
                A_IDLE: begin
                    if (state_q == S_REPORT) begin
                        tx_data_q  <= status_q;
                        tx_start_q <= 1'b1;
                        ack_q      <= A_WAIT;
                    end
                end
                A_WAIT: begin
                    // A status arriving while the previous byte is still in flight is lost.
                    if (state_q == S_REPORT) ovf_q <= 1'b1;
                    if (i_tx_done_tick)      ack_q <= A_IDLE;
                end
                default: ack_q <= A_IDLE;
            endcase
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_ack_ovf  = ovf_q;
`else
    logic unused_ack;
    assign unused_ack = i_tx_done_tick ^ (^status_q);

    assign o_tx_start = 1'b0;
    assign o_tx_data  = 8'h00;
    assign o_ack_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_packet_sequencer.sv
// Randomized bench for pattern_packet_sequencer against a packet-level reference model.
// Status echo expectations follow PKT_SEQ_ACK_EN.
module tb_pattern_packet_sequencer;

    localparam int DATA_BIT    = 32;
    localparam int PACK_NUM    = 9;
    localparam int CH_NUM      = 3;
    localparam int TIMEOUT_CLK = 10420;
    localparam int TO_BIT      = 14;
`ifdef PKT_SEQ_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [7:0]          i_data = '0;
    logic                i_rx_done_tick = 1'b0;
    logic [CH_NUM-1:0]   i_busy = '0;
    logic                i_tx_done_tick = 1'b0;
    logic [DATA_BIT-1:0] o_out_pattern, o_freq_pattern;
    logic                o_mode, o_idle_level, o_tx_start, o_err_tick, o_ack_ovf;
    logic [CH_NUM-1:0]   o_load, o_start, o_stop;
    logic [7:0]          o_tx_data;

    always #50 clk = ~clk;

    pattern_packet_sequencer #(
        .DATA_BIT(DATA_BIT), .PACK_NUM(PACK_NUM), .CH_NUM(CH_NUM),
        .TIMEOUT_CLK(TIMEOUT_CLK), .TO_BIT(TO_BIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_rx_done_tick(i_rx_done_tick),
        .i_busy(i_busy), .o_out_pattern(o_out_pattern), .o_freq_pattern(o_freq_pattern),
        .o_mode(o_mode), .o_idle_level(o_idle_level), .o_load(o_load), .o_start(o_start),
        .o_stop(o_stop), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_done_tick(i_tx_done_tick), .o_err_tick(o_err_tick), .o_ack_ovf(o_ack_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: last loaded channel settings and ACK path occupancy.
    logic [31:0] m_out = '0, m_freq = '0;
    logic        m_mode = 1'b0, m_idle = 1'b0;
    bit          m_ack_wait = 1'b0, m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        i_data = b;
        i_rx_done_tick = 1'b1;
        @(negedge clk);
        i_rx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_pat", 64'(o_out_pattern), 64'd0);
        check("rst_freq_pat", 64'(o_freq_pattern), 64'd0);
        check("rst_strobes", 64'({o_load, o_start, o_stop}), 64'd0);
        check("rst_misc", 64'({o_mode, o_idle_level, o_err_tick, o_tx_start, o_ack_ovf}), 64'd0);
        check("rst_tx_data", 64'(o_tx_data), 64'd0);
        rst_n = 1'b0;
        m_out = '0; m_freq = '0; m_mode = 1'b0; m_idle = 1'b0;
        m_ack_wait = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic run_packet(input logic [31:0] outp, input logic [31:0] freq,
                              input logic [7:0] ctrl, input logic [CH_NUM-1:0] busy,
                              input bit ack, input int maxgap);
        logic [71:0]       pkt;
        logic [CH_NUM-1:0] oh, stray;
        logic [7:0]        status, tx_seen;
        int                ch, cmd, code, err_cnt, tx_cnt, txk;
        bit                ld, st, sp, tx_exp;
        pkt = {ctrl, freq, outp};
        i_busy = busy;
        for (int i = 0; i < PACK_NUM; i++) send_byte(pkt[i*8 +: 8], maxgap);

        ch  = int'(ctrl[7:4]);
        cmd = int'(ctrl[1:0]);
        oh  = '0;
        if (ch < CH_NUM) oh[ch] = 1'b1;
        if (ch >= CH_NUM || cmd == 3) code = 1;
        else if (cmd == 0)            code = 0;
        else if ((busy & oh) != 0)    code = 2;
        else                          code = 0;
        sp = (code == 0) && (cmd == 0);
        ld = (code == 0) && (cmd != 0);
        st = ld && (cmd == 1);
        if (ld) begin
            m_out = outp; m_freq = freq; m_mode = ctrl[2]; m_idle = ctrl[3];
        end
        status = {ctrl[7:4], 2'b00, 2'(code)};
        tx_exp = ACK_EN && !m_ack_wait;
        if (ACK_EN && m_ack_wait) m_ovf = 1'b1;
        if (tx_exp && !ack) m_ack_wait = 1'b1;

        err_cnt = 0; tx_cnt = 0; txk = -10; stray = '0; tx_seen = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            i_tx_done_tick = ack && (k == txk + 2);
            if (k == 2) begin
                check("load", 64'(o_load), 64'(ld ? oh : '0));
                check("stop", 64'(o_stop), 64'(sp ? oh : '0));
                check("out_pattern", 64'(o_out_pattern), 64'(m_out));
                check("freq_pattern", 64'(o_freq_pattern), 64'(m_freq));
                check("mode_idle", 64'({o_mode, o_idle_level}), 64'({m_mode, m_idle}));
            end else begin
                stray |= o_load | o_stop;
            end
            if (k == 3) check("start", 64'(o_start), 64'(st ? oh : '0));
            else        stray |= o_start;
            if (o_err_tick) err_cnt++;
            if (o_tx_start) begin
                tx_cnt++;
                tx_seen = o_tx_data;
                txk = k;
            end
        end
        i_tx_done_tick = 1'b0;
        check("stray_strobe", 64'(stray), 64'd0);
        check("err_tick_cnt", 64'(err_cnt), 64'((code != 0) ? 1 : 0));
        check("tx_cnt", 64'(tx_cnt), 64'(tx_exp ? 1 : 0));
        check("tx_data", 64'(tx_seen), 64'(tx_exp ? status : 8'h00));
        check("ack_ovf", 64'(o_ack_ovf), 64'(m_ovf));
    endtask

    task automatic run_timeout();
        int first, errs, tx_cnt, txk;
        logic [7:0] tx_seen;
        bit tx_exp;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 2);
        tx_exp = ACK_EN && !m_ack_wait;
        first = -1; errs = 0; tx_cnt = 0; txk = -10; tx_seen = '0;
        for (int k = 1; k <= TIMEOUT_CLK + 20; k++) begin
            if (k > 1) @(negedge clk);
            i_tx_done_tick = (k == txk + 2);
            if (o_err_tick) begin
                errs++;
                if (first < 0) first = k;
            end
            if (o_tx_start) begin
                tx_cnt++;
                tx_seen = o_tx_data;
                txk = k;
            end
        end
        i_tx_done_tick = 1'b0;
        check("to_err_cnt", 64'(errs), 64'd1);
        check("to_not_early", 64'(first >= TIMEOUT_CLK - 2), 64'd1);
        check("to_not_late", 64'(first <= TIMEOUT_CLK + 4), 64'd1);
        check("to_tx_cnt", 64'(tx_cnt), 64'(tx_exp ? 1 : 0));
        check("to_tx_data", 64'(tx_seen), 64'(tx_exp ? 8'hF3 : 8'h00));
        check("to_no_load", 64'({o_load, o_start, o_stop}), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("init_out_pat", 64'(o_out_pattern), 64'd0);
        check("init_strobes", 64'({o_load, o_start, o_stop, o_err_tick, o_tx_start}), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);

        run_packet(32'h00FF00FF, 32'h0, 8'h01, 3'b000, 1'b1, 0);
        run_packet(32'h12345678, 32'h9ABCDEF0, 8'h15, 3'b000, 1'b1, 1);
        run_packet(32'hDEADBEEF, 32'h0BADF00D, 8'h31, 3'b000, 1'b1, 2);
        run_packet(32'hCAFEF00D, 32'h13579BDF, 8'h21, 3'b100, 1'b1, 0);
        run_packet(32'h0, 32'h0, 8'h20, 3'b100, 1'b1, 1);
        run_packet(32'hA5A5A5A5, 32'h5A5A5A5A, 8'h0B, 3'b000, 1'b1, 0);
        run_packet(32'h11111111, 32'h22222222, 8'h13, 3'b000, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            run_packet($urandom, $urandom,
                       {4'($urandom_range(4, 0)), 4'($urandom)},
                       3'($urandom), 1'b1, 3);
        end

        run_timeout();
        run_packet(32'h0F0F0F0F, 32'hF0F0F0F0, 8'h0D, 3'b000, 1'b1, 1);

        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
        do_reset();
        run_packet(32'h87654321, 32'h24681357, 8'h25, 3'b000, 1'b1, 1);

        run_packet(32'h01020304, 32'h05060708, 8'h02, 3'b000, 1'b0, 0);
        run_packet(32'h11223344, 32'h55667788, 8'h12, 3'b000, 1'b1, 0);
        do_reset();
        run_packet(32'hFEDCBA98, 32'h76543210, 8'h19, 3'b000, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_packet_sequencer.md
Name: pattern_packet_sequencer

Overview:
- Sits between the UART RX/TX pair and the multi-channel diff-frequency serial-out bank.
- Assembles 9-byte command packets from RX byte ticks: 32-bit output pattern, 32-bit frequency pattern, then 8-bit control.
- Validates each packet, loads one channel's pattern registers, and issues start/stop strobes to that channel.
- Returns a one-byte status through the UART TX handshake.

Parameters:
- DATA_BIT, 32: width of output and frequency patterns.
- PACK_NUM, 9: bytes per packet; must equal 2*DATA_BIT/8+1.
- CH_NUM, 3: number of serial-out channels, 1..15.
- TIMEOUT_CLK, 10420: inter-byte timeout in clk cycles (≈2 byte times at 19200 baud, 10 MHz).
- TO_BIT, 14: counter width; must be ≥ log2(TIMEOUT_CLK).

Ports:
- clk  in  1  system clock, 10 MHz
- rst_n  in  1  reset, asynchronous, active-high
- i_data  in  8  RX byte
- i_rx_done_tick  in  1  RX byte valid, one-cycle
- i_busy  in  CH_NUM  per-channel busy level
- o_out_pattern  out  DATA_BIT  shared pattern bus
- o_freq_pattern  out  DATA_BIT  shared frequency bus
- o_mode  out  1  0 = one-shot, 1 = repeat
- o_idle_level  out  1  channel idle output level
- o_load  out  CH_NUM  one-hot load strobe
- o_start  out  CH_NUM  one-hot start strobe
- o_stop  out  CH_NUM  one-hot stop strobe
- o_tx_start  out  1  TX byte request pulse
- o_tx_data  out  8  status byte
- i_tx_done_tick  in  1  TX byte complete
- o_err_tick  out  1  one-cycle pulse on any non-OK status
- o_ack_ovf  out  1  sticky: status dropped because TX path was busy

Behaviour:
- Reset: all outputs 0; byte count 0; FSMs in IDLE.
- Collection (runs independently of dispatch):
  - Each i_rx_done_tick shifts {i_data, buf[71:8]} and increments count. Byte0 ends up in buf[7:0].
  - Field mapping: out_pattern = buf[31:0] (LSB byte first); freq_pattern = buf[63:32]; ctrl = buf[71:64].
  - When count reaches PACK_NUM, buf is copied to a hold register in the same cycle and count returns to 0. No byte is lost.
- Timeout:
  - The timeout counter runs only while count > 0, and clears on every byte.
  - On reaching TIMEOUT_CLK-1, the packet is discarded, count returns to 0, and status TIMEOUT is raised.
  - If a byte tick and expiry occur in the same cycle, the byte wins and no timeout fires.
- Control byte fields:
  - ctrl[7:4] = channel.
  - ctrl[3] = idle level.
  - ctrl[2] = mode.
  - ctrl[1:0] = cmd: 00 stop, 01 load+start, 10 load only, 11 reserved.
- Dispatch FSM (IDLE, DECODE, LOAD, START, REPORT):
  - Last byte tick at cycle T → DECODE at T+1.
  - In DECODE:
    - channel ≥ CH_NUM or cmd = 11 → INVALID.
    - cmd = 00 → o_stop[ch] pulses at T+2; status OK; stop is honoured even while busy.
    - cmd = 01/10 with i_busy[ch] high → BUSY; nothing loaded.
    - Otherwise → LOAD: at T+2, pattern buses, o_mode and o_idle_level update and o_load[ch] pulses. Buses hold until the next LOAD.
    - cmd = 01 → START: o_start[ch] pulses at T+3.
  - Every packet ends in REPORT (one cycle), then IDLE.
- Status byte: {channel, 2'b00, code}.
  - Codes: 00 OK, 01 INVALID, 10 BUSY, 11 TIMEOUT.
  - TIMEOUT reports channel 4'hF.
  - o_err_tick pulses in the REPORT cycle when code ≠ 00.
- ACK FSM (A_IDLE, A_WAIT):
  - On REPORT with A_IDLE: latch o_tx_data, pulse o_tx_start for 1 cycle, go to A_WAIT until i_tx_done_tick.
  - REPORT while in A_WAIT: the status is dropped and o_ack_ovf is set (cleared only by reset).
- Reset mid-packet or mid-ack aborts immediately. No strobe is emitted after reset release until a full new packet arrives.

Optional Feature:
- Macro PKT_SEQ_ACK_EN.
- Defined: ACK FSM and status echo present as described.
- Undefined:
  - ACK FSM removed.
  - o_tx_start, o_tx_data and o_ack_ovf tied to 0; i_tx_done_tick ignored.
  - o_err_tick still functional.

Decomposition:
- Shared package pattern_pkg:
  - cmd encodings: CMD_STOP, CMD_LOAD_START, CMD_LOAD, CMD_RSVD.
  - status codes: ST_OK, ST_INVALID, ST_BUSY, ST_TIMEOUT.
  - MODE_ONE_SHOT / MODE_REPEAT and IDLE_LOW / IDLE_HIGH constants.
  - ctrl-byte field bit positions.
- One sub-module: pkt_byte_collector (shift buffer, count, timeout, hold-register handoff).

Test Plan:
- Packet FF,00,FF,00,00,00,00,00 then 0x01 with all channels idle → o_out_pattern = 32'h00FF00FF, o_load = 3'b001 at T+2, o_start = 3'b001 at T+3, status byte 0x00.
- Ctrl 0x15 (ch1, repeat, load+start) → o_mode = 1, o_load = 3'b010, o_start = 3'b010, tx 0x10.
- Ctrl 0x31 (ch3, CH_NUM = 3) → no strobes, o_err_tick, tx 0x31.
- i_busy[2] = 1 with ctrl 0x21 → no load, tx 0x22; then ctrl 0x20 → o_stop = 3'b100, tx 0x20.
- 4 bytes then silence for TIMEOUT_CLK cycles → discard, tx 0xF3; next full packet decodes correctly.
- Assert rst_n for 1 cycle after byte 5, then send a full packet → only the new packet is dispatched; pattern bus matches the new data.
